multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM: the producer side of the 3-bit ALU function code (F) consumed by alu32.
//  Sequences fetch/decode/execute per instruction and drives datapath mux selects, write enables and alucontrol.
//  Sits between the instruction register (op/funct) and the multicycle datapath; reads ALU Zero for branches.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word opcode
//  OP_SW     6'b101011  store word opcode
//  OP_BEQ    6'b000100  branch-if-equal opcode
//  OP_ADDI   6'b001000  add immediate opcode
//  OP_J      6'b000010  jump opcode
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  reset_n     in   1  asynchronous active-low reset
//  op          in   6  instruction[31:26], sampled in DECODE
//  funct       in   6  instruction[5:0], used in EXEC
//  zero        in   1  ALU Zero flag, used in BRANCH
//  iord        out  1  memory address select: 0=PC, 1=ALUOut
//  memwrite    out  1  data memory write enable
//  irwrite     out  1  instruction register load enable
//  regdst      out  1  write-register select: 0=rt, 1=rd
//  memtoreg    out  1  write-data select: 0=ALUOut, 1=Data
//  regwrite    out  1  register file write enable
//  alusrca     out  1  ALU A select: 0=PC, 1=regA
//  alusrcb     out  2  ALU B select: 00=regB 01=4 10=SignImm 11=SignImm<<2
//  pcsrc       out  2  next-PC select: 00=ALUResult 01=ALUOut 10=jump target
//  alucontrol  out  3  ALU F code: 010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcen        out  1  PC load enable = pcwrite | (branch & zero)
//  state       out  4  current state (debug/verification)
// BEHAVIOUR
//  States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7
//   BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11; codes 12-15 unreachable, next state FETCH.
//  Transitions: FETCH->DECODE always. DECODE: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH,
//   ADDI->ADDIEX, J->JUMP, any other op->FETCH (treated as NOP; PC already advanced).
//   MEMADR: op==LW->MEMRD, else MEMWR. MEMRD->MEMWB. EXEC->ALUWB. ADDIEX->ADDIWB.
//   MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
//  Outputs are Moore (decoded from state) except pcen (uses zero) and alucontrol in EXEC (uses funct).
//  Default every output 0, alucontrol=010, unless listed:
//   FETCH: irwrite=1 alusrcb=01 pcwrite=1        DECODE: alusrcb=11 (branch target precompute)
//   MEMADR/ADDIEX: alusrca=1 alusrcb=10          MEMRD: iord=1
//   MEMWB: memtoreg=1 regwrite=1                 MEMWR: iord=1 memwrite=1
//   EXEC: alusrca=1 alucontrol=f(funct)          ALUWB: regdst=1 regwrite=1
//   BRANCH: alusrca=1 alucontrol=110 pcsrc=01 branch=1   ADDIWB: regwrite=1
//   JUMP: pcsrc=10 pcwrite=1
//  funct map: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; other->010.
//  Cycles per instruction: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, unknown op 2.
//  Reset: reset_n low -> state=FETCH immediately, asynchronously, including mid-instruction; while low
//   irwrite, pcen, memwrite, regwrite forced 0, all other outputs at FETCH values.
//   First rising edge after release executes FETCH.
//  zero is only honoured in BRANCH; a zero change in any other state has no effect on pcen.
//  op/funct must be stable from DECODE through the last state of the instruction (IR held, irwrite=0).
// TESTING
//  reset_n=0 at EXEC of R-type -> state=0 same cycle, irwrite=pcen=regwrite=0; release -> FETCH then DECODE.
//  LW (op=100011) -> states 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1 memtoreg=1 regdst=0.
//  BEQ zero=1 -> BRANCH pcen=1 pcsrc=01 alucontrol=110; repeat with zero=0 -> pcen=0, next FETCH.
//  R-type funct=101010 -> EXEC alucontrol=111; ALUWB regdst=1 regwrite=1; 4 cycles total.
//  SW -> states 0,1,2,5,0; MEMWR memwrite=1 iord=1; regwrite=0 throughout.
//  op=111111 -> FETCH,DECODE,FETCH, no memwrite/regwrite; J -> JUMP pcsrc=10 pcen=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. It steps each instruction
//   through fetch/decode/execute states and drives the datapath mux selects,
//   the write enables and the 3-bit ALU function code consumed by alu32.
//
// Ports
//   clk         in   1  clock; all state updates on the rising edge
//   reset_n     in   1  asynchronous active-low reset
//   op          in   6  instruction[31:26]; sampled in DECODE
//   funct       in   6  instruction[5:0]; used in EXEC
//   zero        in   1  ALU Zero flag; honoured only in BRANCH
//   iord        out  1  memory address select (0=PC, 1=ALUOut)
//   memwrite    out  1  data memory write enable
//   irwrite     out  1  instruction register load enable
//   regdst      out  1  write-register select (0=rt, 1=rd)
//   memtoreg    out  1  write-data select (0=ALUOut, 1=Data)
//   regwrite    out  1  register file write enable
//   alusrca     out  1  ALU A select (0=PC, 1=regA)
//   alusrcb     out  2  ALU B select (00=regB 01=4 10=SignImm 11=SignImm<<2)
//   pcsrc       out  2  next-PC select (00=ALUResult 01=ALUOut 10=jump)
//   alucontrol  out  3  ALU F code (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   pcen        out  1  PC load enable = pcwrite | (branch & zero)
//   state       out  4  current state, for debug/verification
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e state_q, state_d;

  // Ungated versions of the enables that reset must suppress.
  logic irwrite_raw, memwrite_raw, regwrite_raw;
  logic pcwrite, branch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = 3'b010;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset already forces FETCH, so only the state-changing enables need
  // explicit gating to keep memory, registers and PC untouched during reset.
  assign irwrite  = irwrite_raw  & reset_n;
  assign memwrite = memwrite_raw & reset_n;
  assign regwrite = regwrite_raw & reset_n;
  assign pcen     = (pcwrite | (branch & zero)) & reset_n;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Output bundle order:
  // iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc alucontrol pcen
  logic [14:0] outs;
  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, pcen};

  localparam logic [14:0] O_RESET  = 15'b0_0_0_0_0_0_0_01_00_010_0;
  localparam logic [14:0] O_FETCH  = 15'b0_0_1_0_0_0_0_01_00_010_1;
  localparam logic [14:0] O_DECODE = 15'b0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [14:0] O_MEMADR = 15'b0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [14:0] O_MEMRD  = 15'b1_0_0_0_0_0_0_00_00_010_0;
  localparam logic [14:0] O_MEMWB  = 15'b0_0_0_0_1_1_0_00_00_010_0;
  localparam logic [14:0] O_MEMWR  = 15'b1_1_0_0_0_0_0_00_00_010_0;
  localparam logic [14:0] O_EXSLT  = 15'b0_0_0_0_0_0_1_00_00_111_0;
  localparam logic [14:0] O_EXSUB  = 15'b0_0_0_0_0_0_1_00_00_110_0;
  localparam logic [14:0] O_ALUWB  = 15'b0_0_0_1_0_1_0_00_00_010_0;
  localparam logic [14:0] O_BRTAK  = 15'b0_0_0_0_0_0_1_00_01_110_1;
  localparam logic [14:0] O_BRNOT  = 15'b0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [14:0] O_ADDIWB = 15'b0_0_0_0_0_1_0_00_00_010_0;
  localparam logic [14:0] O_JUMP   = 15'b0_0_0_0_0_0_0_00_10_010_1;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010,
                         BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [14:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [3:0] s, input logic [14:0] e);
    vec_t v;
    v.rst_n = r; v.op = o; v.funct = f; v.zero = z; v.st = s; v.out = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input string tag, input logic r, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input logic [3:0] s,
                      input logic [14:0] e);
    @(negedge clk);
    reset_n = r; op = o; funct = f; zero = z;
    #1;
    check({tag, ".state"}, {11'd0, state}, {11'd0, s});
    check({tag, ".outs"}, outs, e);
  endtask

  logic [5:0] fcodes[5];
  logic [2:0] fexp[5];

  initial begin
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0;

    add(0, LW,   6'd0,      0, 4'd0,  O_RESET);
    add(1, LW,   6'd0,      0, 4'd0,  O_FETCH);
    add(1, LW,   6'd0,      0, 4'd1,  O_DECODE);
    add(1, LW,   6'd0,      0, 4'd2,  O_MEMADR);
    add(1, LW,   6'd0,      0, 4'd3,  O_MEMRD);
    add(1, LW,   6'd0,      0, 4'd4,  O_MEMWB);
    add(1, SW,   6'd0,      0, 4'd0,  O_FETCH);
    add(1, SW,   6'd0,      0, 4'd1,  O_DECODE);
    add(1, SW,   6'd0,      0, 4'd2,  O_MEMADR);
    add(1, SW,   6'd0,      0, 4'd5,  O_MEMWR);
    add(1, RT,   6'b101010, 0, 4'd0,  O_FETCH);
    add(1, RT,   6'b101010, 0, 4'd1,  O_DECODE);
    add(1, RT,   6'b101010, 0, 4'd6,  O_EXSLT);
    add(1, RT,   6'b101010, 0, 4'd7,  O_ALUWB);
    add(1, BEQ,  6'd0,      1, 4'd0,  O_FETCH);
    add(1, BEQ,  6'd0,      1, 4'd1,  O_DECODE);
    add(1, BEQ,  6'd0,      1, 4'd8,  O_BRTAK);
    add(1, BEQ,  6'd0,      0, 4'd0,  O_FETCH);
    add(1, BEQ,  6'd0,      0, 4'd1,  O_DECODE);
    add(1, BEQ,  6'd0,      0, 4'd8,  O_BRNOT);
    add(1, BAD,  6'd0,      0, 4'd0,  O_FETCH);
    add(1, BAD,  6'd0,      1, 4'd1,  O_DECODE);
    add(1, JMP,  6'd0,      0, 4'd0,  O_FETCH);
    add(1, JMP,  6'd0,      0, 4'd1,  O_DECODE);
    add(1, JMP,  6'd0,      0, 4'd11, O_JUMP);
    add(1, ADDI, 6'd0,      0, 4'd0,  O_FETCH);
    add(1, ADDI, 6'd0,      0, 4'd1,  O_DECODE);
    add(1, ADDI, 6'd0,      0, 4'd9,  O_MEMADR);
    add(1, ADDI, 6'd0,      1, 4'd10, O_ADDIWB);
    add(1, RT,   6'b100010, 0, 4'd0,  O_FETCH);
    add(1, RT,   6'b100010, 0, 4'd1,  O_DECODE);
    add(1, RT,   6'b100010, 1, 4'd6,  O_EXSUB);
    add(1, RT,   6'b100010, 1, 4'd7,  O_ALUWB);
    add(1, RT,   6'b100010, 0, 4'd0,  O_FETCH);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].op, vecs[i].funct,
           vecs[i].zero, vecs[i].st, vecs[i].out);

    // Remaining funct decodes, including an unlisted one that falls back to add.
    fcodes[0] = 6'b100000; fexp[0] = 3'b010;
    fcodes[1] = 6'b100100; fexp[1] = 3'b000;
    fcodes[2] = 6'b100101; fexp[2] = 3'b001;
    fcodes[3] = 6'b000111; fexp[3] = 3'b010;
    fcodes[4] = 6'b101010; fexp[4] = 3'b111;
    for (int k = 0; k < 5; k++) begin
      step("fn.decode", 1, RT, fcodes[k], 0, 4'd1, O_DECODE);
      step($sformatf("fn%0d.exec", k), 1, RT, fcodes[k], 0, 4'd6,
           {7'b0000001, 2'b00, 2'b00, fexp[k], 1'b0});
      step("fn.aluwb", 1, RT, fcodes[k], 0, 4'd7, O_ALUWB);
      step("fn.fetch", 1, RT, fcodes[k], 0, 4'd0, O_FETCH);
    end

    // Asynchronous reset in the middle of an R-type EXEC.
    step("ar.decode", 1, RT, 6'b100000, 0, 4'd1, O_DECODE);
    @(posedge clk);
    #1;
    check("ar.in_exec", {11'd0, state}, 15'd6);
    #2 reset_n = 1'b0;
    #1;
    check("ar.async_state", {11'd0, state}, 15'd0);
    check("ar.async_outs", outs, O_RESET);
    step("ar.held", 0, RT, 6'b100000, 0, 4'd0, O_RESET);
    step("ar.rel_fetch", 1, RT, 6'b100000, 0, 4'd0, O_FETCH);
    step("ar.rel_decode", 1, RT, 6'b100000, 0, 4'd1, O_DECODE);
    step("ar.exec", 1, RT, 6'b100000, 0, 4'd6,
         {7'b0000001, 2'b00, 2'b00, 3'b010, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
